legv8_instr_encoder: RTL
========================

# legv8_instr_encoder

Sequential instruction writer for the LEGv8 single-cycle datapath: accepts a stream of decoded instruction commands over a valid/ready handshake, encodes each into a 32-bit R-, D- or CB-format word, and writes it to instruction memory at consecutive word addresses. It is the program-load counterpart of the control decoder, and produces exactly the opcode fields that decoder recognises (ADD/SUB/AND/ORR, LDUR, STUR, CBZ).

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity 2^ADDR_W words.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin load session (sampled only in IDLE).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  encoder accepts command this cycle.
- cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal.
- cmd_rd  in  5  Rd (R-type) / Rt (D, CB).
- cmd_rn  in  5  Rn.
- cmd_rm  in  5  Rm (R-type only).
- cmd_imm  in  19  D: bits [8:0] = DT_address; CB: full 19-bit offset.
- cmd_last  in  1  final command of session.
- mem_we  out  1  write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- done  out  1  one-cycle pulse at end of session.
- err  out  1  sticky: illegal op or memory overflow.
- count  out  ADDR_W+1  words written this session.

## Operation
- States: IDLE, RUN, WRITE, DONE (plus PAD under macro).
- IDLE: cmd_ready=0; start=1 -> RUN, clears count, err, write pointer.
- RUN: cmd_ready=1. Handshake (valid&ready) registers encoded word and last flag.
  - Legal op -> WRITE.
  - Op 7 -> word dropped, err=1; if cmd_last -> DONE else stay RUN.
- WRITE: mem_we=1, mem_addr=pointer, mem_wdata=registered word; pointer and count increment. Then cmd_last -> DONE; pointer wrapped to 0 (count == 2^ADDR_W) -> err=1, DONE; else RUN.
- DONE: done=1 one cycle -> IDLE.
- Encoding: R: [31:21] opcode (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), [20:16] Rm, [15:10] shamt=0, [9:5] Rn, [4:0] Rd. D: [31:21] LDUR 11111000010 / STUR 11111000000, [20:12] imm[8:0], [11:10]=00, [9:5] Rn, [4:0] Rt. CB: [31:24] 10110100, [23:5] imm19, [4:0] Rt. Unused command fields ignored.
- start outside IDLE ignored; cmd_valid outside RUN ignored.

## Timing
- Reset: state IDLE; cmd_ready, mem_we, done, err = 0; mem_addr, mem_wdata, count = 0.
- Reset mid-session: next edge IDLE, partial write abandoned, no done pulse.
- Handshake at edge N -> mem_we high during cycle N+1; throughput one word per two cycles.
- Last write at edge M -> done high cycle M+1; next start accepted from cycle M+2.
- mem_wdata/mem_addr hold last values when mem_we=0.

## Configuration
- LEGV8_ENC_HALT_PAD_EN defined: after last legal write (not on overflow), extra PAD state writes 32'h00000000 at next address (count +1) before DONE; done delayed one cycle. If pointer already wrapped, no pad, err set.
- Undefined: WRITE goes directly to DONE; no pad word.

## Structure
- Package legv8_pkg: cmd_op enum, 11-bit opcode constants (ADD/SUB/AND/ORR/LDUR/STUR), 8-bit CBZ constant, FSM state enum.
- One combinational sub-module legv8_encode (op, rd, rn, rm, imm -> word, illegal); FSM, pointer, handshake in top.

## Test plan
- start, ADD rd=1 rn=2 rm=3 last -> mem_we at addr 0, wdata 32'h8B030041; done next cycle; count=1.
- LDUR rt=5 rn=6 imm=8, STUR rt=1 rn=2 imm=0, CBZ rt=9 imm=4 (last) -> 32'hF84080C5 @0, 32'hF8000041 @1, 32'hB4000089 @2.
- Op 7 then SUB rd=0 rn=0 rm=0 last -> err=1, single write 32'hCB000000 at addr 0, count=1.
- ADDR_W=2, five commands, none last -> four writes addr 0..3, err=1, done, fifth not accepted.
- rst_n low one cycle between handshake and WRITE -> no mem_we, all outputs 0, no done.
- With LEGV8_ENC_HALT_PAD_EN: single ADD last -> extra write 32'h0 at addr 1, count=2, done one cycle later.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and opcode constants for the LEGv8 instruction encoder.
// Defining LEGV8_ENC_HALT_PAD_EN adds a trailing zero pad word after the last write.
package legv8_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_AND     = 3'd2,
        OP_ORR     = 3'd3,
        OP_LDUR    = 3'd4,
        OP_STUR    = 3'd5,
        OP_CBZ     = 3'd6,
        OP_ILLEGAL = 3'd7
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        WRITE = 3'd2,
        PAD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    function automatic logic [31:0] r_word(input logic [10:0] opc, input logic [4:0] rm,
                                           input logic [4:0] rn, input logic [4:0] rd);
        return {opc, rm, 6'b000000, rn, rd};
    endfunction

    function automatic logic [31:0] d_word(input logic [10:0] opc, input logic [8:0] dt,
                                           input logic [4:0] rn, input logic [4:0] rt);
        return {opc, dt, 2'b00, rn, rt};
    endfunction

endpackage

// File: rtl/legv8_encode.sv
// Combinational encoder: one decoded command into an R-, D- or CB-format word.
// Op 7 yields a zero word and raises illegal.
module legv8_encode
    import legv8_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [18:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cmd_op_t'(op))
            OP_ADD:  word = r_word(OPC_ADD, rm, rn, rd);
            OP_SUB:  word = r_word(OPC_SUB, rm, rn, rd);
            OP_AND:  word = r_word(OPC_AND, rm, rn, rd);
            OP_ORR:  word = r_word(OPC_ORR, rm, rn, rd);
            OP_LDUR: word = d_word(OPC_LDUR, imm[8:0], rn, rd);
            OP_STUR: word = d_word(OPC_STUR, imm[8:0], rn, rd);
            OP_CBZ:  word = {OPC_CBZ, imm, rd};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Program loader: accepts commands over valid/ready, encodes them and writes
// consecutive instruction-memory words. Optional LEGV8_ENC_HALT_PAD_EN appends a zero word.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rn,
    input  logic [4:0]        cmd_rm,
    input  logic [18:0]       cmd_imm,
    input  logic              cmd_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic                last_q;
    logic [31:0]         enc_word;
    logic                enc_illegal;

    legv8_encode u_encode (
        .op      (cmd_op),
        .rd      (cmd_rd),
        .rn      (cmd_rn),
        .rm      (cmd_rm),
        .imm     (cmd_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // The encoded word goes straight into mem_wdata at the handshake, so it is
    // the registered copy that WRITE presents to memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            ptr       <= '0;
            last_q    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        cmd_ready <= 1'b1;
                        count     <= '0;
                        err       <= 1'b0;
                        ptr       <= '0;
                    end
                end
                RUN: begin
                    if (cmd_valid && cmd_ready) begin
                        last_q <= cmd_last;
                        if (enc_illegal) begin
                            err <= 1'b1;
                            if (cmd_last) begin
                                state     <= DONE;
                                cmd_ready <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else begin
                            state     <= WRITE;
                            cmd_ready <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr;
                            mem_wdata <= enc_word;
                        end
                    end
                end
                WRITE: begin
                    ptr   <= ptr + 1'b1;
                    count <= count + 1'b1;
                    if (last_q) begin
`ifdef LEGV8_ENC_HALT_PAD_EN
                        if (ptr == '1) begin
                            err   <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= PAD;
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr + 1'b1;
                            mem_wdata <= '0;
                        end
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end else if (ptr == '1) begin
                        // Pointer wraps to 0 on this write: memory is full.
                        err   <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        cmd_ready <= 1'b1;
                    end
                end
`ifdef LEGV8_ENC_HALT_PAD_EN
                PAD: begin
                    ptr   <= ptr + 1'b1;
                    count <= count + 1'b1;
                    state <= DONE;
                    done  <= 1'b1;
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
